// File: rtl/fwd_hazard_if.sv
// fwd_hazard_if: ID-stage decoder <-> forwarding/hazard controller signals.
// HAZARD_STATS_EN adds the stall_cnt/fwd_cnt statistics outputs.
interface fwd_hazard_if;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic [4:0] id_dst;
   logic       id_regwrite;
   logic       id_memread;
   logic       id_multi;
   logic       flush;
   logic [1:0] fwd_a_sel;
   logic [1:0] fwd_b_sel;
   logic       stall;
   logic       md_busy;
`ifdef HAZARD_STATS_EN
   logic [15:0] stall_cnt;
   logic [15:0] fwd_cnt;
   modport master (output id_valid, id_rs, id_rt, id_dst, id_regwrite, id_memread, id_multi, flush,
                   input fwd_a_sel, fwd_b_sel, stall, md_busy, stall_cnt, fwd_cnt);
   modport slave  (input id_valid, id_rs, id_rt, id_dst, id_regwrite, id_memread, id_multi, flush,
                   output fwd_a_sel, fwd_b_sel, stall, md_busy, stall_cnt, fwd_cnt);
`else
   modport master (output id_valid, id_rs, id_rt, id_dst, id_regwrite, id_memread, id_multi, flush,
                   input fwd_a_sel, fwd_b_sel, stall, md_busy);
   modport slave  (input id_valid, id_rs, id_rt, id_dst, id_regwrite, id_memread, id_multi, flush,
                   output fwd_a_sel, fwd_b_sel, stall, md_busy);
`endif
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX-operand forwarding selects plus load-use and mult/div stall control.
// Define HAZARD_STATS_EN to add saturating stall_cnt/fwd_cnt statistics counters.
module fwd_hazard_ctrl #(
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 4
) (
   input logic        clk,
   input logic        rst,
   fwd_hazard_if.slave bus
);
   typedef struct packed {
      logic       valid;
      logic [4:0] dst;
      logic       regwrite;
      logic       memread;
   } rec_t;

   localparam rec_t BUBBLE = '0;

   // WB needs no record: the write-through register file already serves its data.
   rec_t             ex_q, ex_d, mem_q, mem_d, id_rec;
   logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
   logic [1:0]       a_sel_q, a_sel_d, b_sel_q, b_sel_d;
   logic             issue, load_use, md_busy, hold_bubble;

   function automatic logic hit(input rec_t r, input logic [4:0] src);
      return r.valid & r.regwrite & (|r.dst) & (r.dst == src);
   endfunction

   function automatic logic [1:0] pick(input rec_t ex, input rec_t mem, input logic [4:0] src);
      return hit(ex, src) ? 2'b10 : hit(mem, src) ? 2'b01 : 2'b00;
   endfunction

   always_comb begin
      id_rec      = {1'b1, bus.id_dst, bus.id_regwrite, bus.id_memread};
      issue       = bus.id_valid & ~bus.flush;
      md_busy     = |md_cnt_q;
      load_use    = issue & ex_q.memread & (hit(ex_q, bus.id_rs) | hit(ex_q, bus.id_rt));
      hold_bubble = load_use | ~issue;
      ex_d        = md_busy ? ex_q : hold_bubble ? BUBBLE : id_rec;
      mem_d       = md_busy ? BUBBLE : ex_q;
      a_sel_d     = md_busy ? a_sel_q : hold_bubble ? 2'b00 : pick(ex_q, mem_q, bus.id_rs);
      b_sel_d     = md_busy ? b_sel_q : hold_bubble ? 2'b00 : pick(ex_q, mem_q, bus.id_rt);
      md_cnt_d    = md_busy ? md_cnt_q - 1'b1 :
                    (~hold_bubble & bus.id_multi) ? CNT_W'(MD_LAT - 1) : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q     <= BUBBLE;
         mem_q    <= BUBBLE;
         md_cnt_q <= '0;
         a_sel_q  <= 2'b00;
         b_sel_q  <= 2'b00;
      end else begin
         ex_q     <= ex_d;
         mem_q    <= mem_d;
         md_cnt_q <= md_cnt_d;
         a_sel_q  <= a_sel_d;
         b_sel_q  <= b_sel_d;
      end
   end

   assign bus.fwd_a_sel = a_sel_q;
   assign bus.fwd_b_sel = b_sel_q;
   assign bus.stall     = load_use | md_busy;
   assign bus.md_busy   = md_busy;

`ifdef HAZARD_STATS_EN
   logic [15:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;

   always_comb begin
      stall_cnt_d = (bus.stall & ~&stall_cnt_q) ? stall_cnt_q + 16'd1 : stall_cnt_q;
      fwd_cnt_d   = ((|a_sel_d | |b_sel_d) & ~&fwd_cnt_q) ? fwd_cnt_q + 16'd1 : fwd_cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.fwd_cnt   = fwd_cnt_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed forwarding, load-use, mult/div and async-reset vectors.
module tb_fwd_hazard_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   fwd_hazard_if bus ();

   fwd_hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                        input logic rw, input logic mr, input logic mul, input logic fl);
      bus.id_valid    = v;
      bus.id_rs       = rs;
      bus.id_rt       = rt;
      bus.id_dst      = dst;
      bus.id_regwrite = rw;
      bus.id_memread  = mr;
      bus.id_multi    = mul;
      bus.flush       = fl;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic nop;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      nop();
      #2;
      chk("rst_a", {30'd0, bus.fwd_a_sel}, 32'd0);
      chk("rst_b", {30'd0, bus.fwd_b_sel}, 32'd0);
      chk("rst_stall", {31'd0, bus.stall}, 32'd0);
      chk("rst_busy", {31'd0, bus.md_busy}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      // back-to-back ALU: add $3 ; sub rs=$3
      drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("b2b_stall0", {31'd0, bus.stall}, 32'd0);
      tick();
      drive(1'b1, 5'd3, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("b2b_stall1", {31'd0, bus.stall}, 32'd0);
      tick();
      chk("b2b_a", {30'd0, bus.fwd_a_sel}, 32'd2);
      chk("b2b_b", {30'd0, bus.fwd_b_sel}, 32'd0);
      // distance two: add $5 ; nop ; or rt=$5
      drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      nop();
      tick();
      drive(1'b1, 5'd9, 5'd5, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk("d2_a", {30'd0, bus.fwd_a_sel}, 32'd0);
      chk("d2_b", {30'd0, bus.fwd_b_sel}, 32'd1);
      // $0 never forwards
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk("r0_a", {30'd0, bus.fwd_a_sel}, 32'd0);
      chk("r0_b", {30'd0, bus.fwd_b_sel}, 32'd0);
      // load-use: lw $4 ; add rs=$4
      drive(1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd4, 5'd2, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lu_stall", {31'd0, bus.stall}, 32'd1);
      chk("lu_busy", {31'd0, bus.md_busy}, 32'd0);
      tick();
      chk("lu_bubble_a", {30'd0, bus.fwd_a_sel}, 32'd0);
      chk("lu_stall_once", {31'd0, bus.stall}, 32'd0);
      tick();
      chk("lu_fwd_a", {30'd0, bus.fwd_a_sel}, 32'd1);
      chk("lu_fwd_b", {30'd0, bus.fwd_b_sel}, 32'd0);
      // flushed load-use candidate does not stall
      drive(1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd4, 5'd4, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("lu_flush_stall", {31'd0, bus.stall}, 32'd0);
      tick();
      chk("flush_a", {30'd0, bus.fwd_a_sel}, 32'd0);
      // priority: add $6 ; add $6 ; and rs=rt=$6
      drive(1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd6, 5'd6, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk("prio_a", {30'd0, bus.fwd_a_sel}, 32'd2);
      chk("prio_b", {30'd0, bus.fwd_b_sel}, 32'd2);
      // mult rs=$6 (second add $6 now in MEM -> 01), MD_LAT=4 -> 3 busy cycles
      drive(1'b1, 5'd6, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("md_issue_stall", {31'd0, bus.stall}, 32'd0);
      tick();
      chk("md_a", {30'd0, bus.fwd_a_sel}, 32'd1);
      chk("md_busy1", {31'd0, bus.md_busy}, 32'd1);
      chk("md_stall1", {31'd0, bus.stall}, 32'd1);
      drive(1'b1, 5'd13, 5'd14, 5'd15, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      chk("md_busy2", {31'd0, bus.md_busy}, 32'd1);
      chk("md_hold_a", {30'd0, bus.fwd_a_sel}, 32'd1);
      drive(1'b1, 5'd13, 5'd14, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk("md_busy3", {31'd0, bus.md_busy}, 32'd1);
      tick();
      chk("md_done", {31'd0, bus.md_busy}, 32'd0);
      chk("md_done_stall", {31'd0, bus.stall}, 32'd0);
      tick();
      chk("md_fwd_a", {30'd0, bus.fwd_a_sel}, 32'd2);
      chk("md_mem_bubble_b", {30'd0, bus.fwd_b_sel}, 32'd0);
      // async reset during load-use stall
      drive(1'b1, 5'd15, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      chk("pre_rst_a", {30'd0, bus.fwd_a_sel}, 32'd2);
      drive(1'b1, 5'd4, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("pre_rst_stall", {31'd0, bus.stall}, 32'd1);
      rst = 1'b1;
      #1;
      chk("arst_lu_stall", {31'd0, bus.stall}, 32'd0);
      chk("arst_lu_a", {30'd0, bus.fwd_a_sel}, 32'd0);
      tick();
      rst = 1'b0;
      // async reset during md_busy
      drive(1'b1, 5'd1, 5'd2, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      nop();
      chk("pre_rst_busy", {31'd0, bus.md_busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("arst_md_busy", {31'd0, bus.md_busy}, 32'd0);
      chk("arst_md_stall", {31'd0, bus.stall}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_busy", {31'd0, bus.md_busy}, 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
